int_sequencer: RTL

- Sequences the interrupt/reset entry for the 6502 core: RESET, NMI, IRQ and BRK.
- Arbitrates pending sources by priority and drives the six-cycle entry sequence: dummy cycle, push PCH, push PCL, push P, fetch vector low, fetch vector high.
- Sits beside the instruction decoder. Its strobes are ORed into the PC, stack pointer, status register, DOR, address-register and rw controls while busy is high.

---
 rtl/int_sequencer_pkg.sv | 44 ++++
 rtl/int_sequencer_if.sv | 35 +++
 rtl/int_sequencer_nmi_edge_det.sv | 21 ++
 rtl/int_sequencer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
// Shared encodings for the 6502 interrupt/reset entry sequencer.
// Holds the state and source enums, the default vectors and the registered strobe bundle.
package int_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RST_PEND = 3'd1,
        ST_T1       = 3'd2,
        ST_T2       = 3'd3,
        ST_T3       = 3'd4,
        ST_T4       = 3'd5,
        ST_T5       = 3'd6,
        ST_T6       = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
    localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

    typedef struct packed {
        logic        busy;
        logic        pcinh;
        logic        spadloa;
        logic        spdec;
        logic        pchdboa;
        logic        pcldboa;
        logic        aoa;
        logic        bflag;
        logic        dorwa;
        logic        rw;
        logic        vecrd;
        logic        setirq;
        logic        done;
        logic [15:0] vec_addr;
    } ctl_t;

endpackage

// File: rtl/int_sequencer_if.sv
// Request inputs and control strobes between the decoder side and the interrupt sequencer.
// slave is the sequencer's view; master is the view of whoever drives requests and consumes strobes.
interface int_sequencer_if;
    logic        irq;
    logic        nmi;
    logic        sync;
    logic        idis;
    logic        brk;
    logic        busy;
    logic        pcinh;
    logic        spadloa;
    logic        spdec;
    logic        pchdboa;
    logic        pcldboa;
    logic        aoa;
    logic        bflag;
    logic        dorwa;
    logic        rw;
    logic        vecrd;
    logic        setirq;
    logic        done;
    logic [15:0] vec_addr;

    modport slave (
        input  irq, nmi, sync, idis, brk,
        output busy, pcinh, spadloa, spdec, pchdboa, pcldboa, aoa, bflag,
               dorwa, rw, vecrd, setirq, done, vec_addr
    );

    modport master (
        output irq, nmi, sync, idis, brk,
        input  busy, pcinh, spadloa, spdec, pchdboa, pcldboa, aoa, bflag,
               dorwa, rw, vecrd, setirq, done, vec_addr
    );
endinterface

// File: rtl/int_sequencer_nmi_edge_det.sv
// NMI rising-edge detector: previous-sample flop plus a sticky pending flag.
// A new edge in the same cycle as clear wins, so that NMI is not lost.
module nmi_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic nmi,
    input  logic clear,
    output logic pend
);
    logic nmi_prev;

    always_ff @(posedge clk) begin
        if (clr) begin
            nmi_prev <= 1'b0;
            pend     <= 1'b0;
        end else begin
            nmi_prev <= nmi;
            pend     <= (nmi & ~nmi_prev) | (pend & ~clear);
        end
    end
endmodule

// File: rtl/int_sequencer.sv
// 6502 RESET/NMI/IRQ/BRK entry sequencer driving the six-cycle push-and-vector sequence.
// Define INTSEQ_BRK_EN to honour the brk input; otherwise BRK is ignored and bflag stays 0.
module int_sequencer
    import int_seq_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = VEC_NMI_DEF,
    parameter logic [15:0] VEC_RST = VEC_RST_DEF,
    parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEF
) (
    input logic            clk,
    input logic            clr,
    int_sequencer_if.slave bus
);
    state_t state, nxt_state;
    src_t   src, nxt_src;
    logic   brk_seq, nxt_brk_seq;
    logic   nmi_pend, pend_clear;
    ctl_t   ctl;

    function automatic logic [15:0] vec_base(src_t sr);
        case (sr)
            SRC_NMI:          return VEC_NMI;
            SRC_IRQ, SRC_BRK: return VEC_IRQ;
            default:          return VEC_RST;
        endcase
    endfunction

    // Outputs are decoded from the state being entered so they come straight from flops.
    function automatic ctl_t decode(state_t s, src_t sr, logic bseq);
        ctl_t c;
        logic wr;
        c          = '0;
        c.rw       = 1'b1;
        c.busy     = (s != ST_IDLE);
        c.vec_addr = vec_base(sr);
        wr         = (sr != SRC_RST);
        case (s)
            ST_T1: c.pcinh = 1'b1;
            ST_T2, ST_T3, ST_T4: begin
                c.spadloa = 1'b1;
                c.spdec   = 1'b1;
                c.dorwa   = wr;
                c.rw      = ~wr;
                c.pchdboa = (s == ST_T2);
                c.pcldboa = (s == ST_T3);
                c.aoa     = (s == ST_T4);
                c.bflag   = (s == ST_T4) & bseq;
            end
            ST_T5: c.vecrd = 1'b1;
            ST_T6: begin
                c.vecrd    = 1'b1;
                c.vec_addr = vec_base(sr) + 16'd1;
                c.setirq   = 1'b1;
                c.done     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    nmi_edge_det u_nmi (
        .clk   (clk),
        .clr   (clr),
        .nmi   (bus.nmi),
        .clear (pend_clear),
        .pend  (nmi_pend)
    );

    always_comb begin
        nxt_state   = state;
        nxt_src     = src;
        nxt_brk_seq = brk_seq;
        case (state)
            ST_RST_PEND: begin
                nxt_state = ST_T1;
                nxt_src   = SRC_RST;
            end
            ST_IDLE: begin
                nxt_brk_seq = 1'b0;
                if (bus.sync && nmi_pend) begin
                    nxt_state = ST_T1;
                    nxt_src   = SRC_NMI;
                end else if (bus.sync && bus.irq && !bus.idis) begin
                    nxt_state = ST_T1;
                    nxt_src   = SRC_IRQ;
                end
`ifdef INTSEQ_BRK_EN
                else if (bus.brk) begin
                    nxt_state   = ST_T1;
                    nxt_src     = SRC_BRK;
                    nxt_brk_seq = 1'b1;
                end
`endif
            end
            ST_T1:   nxt_state = ST_T2;
            ST_T2:   nxt_state = ST_T3;
            ST_T3:   nxt_state = ST_T4;
            ST_T4:   nxt_state = ST_T5;
            ST_T5:   nxt_state = ST_T6;
            ST_T6:   nxt_state = ST_IDLE;
            default: nxt_state = ST_RST_PEND;
        endcase
        // A late NMI takes over an IRQ/BRK entry as long as the vector fetch has not begun.
        if (nmi_pend && (src == SRC_IRQ || src == SRC_BRK) &&
            (state == ST_T1 || state == ST_T2 || state == ST_T3 || state == ST_T4))
            nxt_src = SRC_NMI;
    end

    assign pend_clear = (nxt_state == ST_T5) && (nxt_src == SRC_NMI);

`ifndef INTSEQ_BRK_EN
    logic unused_brk;
    assign unused_brk = bus.brk;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= ST_RST_PEND;
            src     <= SRC_RST;
            brk_seq <= 1'b0;
            ctl     <= decode(ST_RST_PEND, SRC_RST, 1'b0);
        end else begin
            state   <= nxt_state;
            src     <= nxt_src;
            brk_seq <= nxt_brk_seq;
            ctl     <= decode(nxt_state, nxt_src, nxt_brk_seq);
        end
    end

    assign bus.busy     = ctl.busy;
    assign bus.pcinh    = ctl.pcinh;
    assign bus.spadloa  = ctl.spadloa;
    assign bus.spdec    = ctl.spdec;
    assign bus.pchdboa  = ctl.pchdboa;
    assign bus.pcldboa  = ctl.pcldboa;
    assign bus.aoa      = ctl.aoa;
    assign bus.bflag    = ctl.bflag;
    assign bus.dorwa    = ctl.dorwa;
    assign bus.rw       = ctl.rw;
    assign bus.vecrd    = ctl.vecrd;
    assign bus.setirq   = ctl.setirq;
    assign bus.done     = ctl.done;
    assign bus.vec_addr = ctl.vec_addr;
endmodule
